// File: rtl/rtc_bus_pkg.sv
// ============================================================================
// Module      : rtc_bus_pkg
// Description : Shared types and constants for the RTC bus sequencer.
//               Holds the sequencer state encoding, default phase widths,
//               the requester-port encoding, the idle strobe levels and a
//               helper that sizes the phase down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtc_bus_pkg;

    // Default dwell times in clk cycles.
    localparam int c_DEF_STROBE_CYC = 8;
    localparam int c_DEF_GAP_CYC    = 4;

    // Bus sequence, one state per phase of a single-byte transaction.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_SU = 3'd1,
        S_ADDR_ST = 3'd2,
        S_ADDR_HD = 3'd3,
        S_DATA_SU = 3'd4,
        S_DATA_ST = 3'd5,
        S_DATA_HD = 3'd6,
        S_RELEASE = 3'd7
    } rtc_state_e;

    // Requester encoding: A is the host/config path, B the refresh reader.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } rtc_port_e;

    // One latched transaction.
    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } rtc_req_t;

    // Strobe levels while the bus is not owned.
    localparam logic       c_CS_N_IDLE    = 1'b1;
    localparam logic       c_WR_N_IDLE    = 1'b1;
    localparam logic       c_RD_N_IDLE    = 1'b1;
    localparam logic       c_AD_IDLE      = 1'b1;
    localparam logic       c_BUS_OE_IDLE  = 1'b0;
    localparam logic [7:0] c_BUS_OUT_IDLE = 8'h00;

    // Width needed to hold max(a,b)-1, never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// ============================================================================
// Module      : rtc_phase_timer
// Description : Phase dwell down-counter. Loaded with (dwell-1) whenever the
//               sequencer enters a new state; last_cyc is high while the
//               count is zero, i.e. in the final cycle of the phase.
//               last_next predicts last_cyc for the following cycle so the
//               sequencer can register outputs that depend on it.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               load, load_val  - reload request and value (dwell-1)
//               last_cyc        - current cycle is the last of the phase
//               last_next       - next cycle will be the last of the phase
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last_cyc,
    output logic             last_next
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign last_cyc  = (r_count == '0);
    // Without a reload the count saturates at zero, so <=1 covers both the
    // final decrement and an already-expired count.
    assign last_next = load ? (load_val == '0) : (r_count <= CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
// ============================================================================
// Module      : rtc_bus_sequencer
// Description : Two-port transaction sequencer/arbiter for the multiplexed
//               8-bit RTC bus. Serialises single-byte reads and writes from
//               port A (host/config) and port B (refresh reader) into an
//               address phase and a data phase with programmable strobe and
//               gap widths. All outputs are registered.
// Parameters  : STROBE_CYC - WR/RD low time per phase (>=1)
//               GAP_CYC    - setup/hold/release interval (>=1)
// Ports       : clk, reset                - clock, sync active-high reset
//               a_/b_req, we, addr, wdata - requests (req held until ack)
//               a_/b_ack, rdata           - completion pulse, last read data
//               busy                      - sequencer not in IDLE
//               cs_n, wr_n, rd_n, ad      - RTC strobes
//               bus_out, bus_oe, bus_in   - shared address/data lines
// Macros      : RTC_RR_ARB_EN - round-robin tie-break instead of A-first
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int STROBE_CYC = c_DEF_STROBE_CYC,
    parameter int GAP_CYC    = c_DEF_GAP_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       a_we,
    input  logic       b_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] b_addr,
    input  logic [7:0] a_wdata,
    input  logic [7:0] b_wdata,
    output logic       a_ack,
    output logic       b_ack,
    output logic [7:0] a_rdata,
    output logic [7:0] b_rdata,
    output logic       busy,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       ad,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    localparam int               c_CNT_W     = cnt_width(STROBE_CYC, GAP_CYC);
    localparam logic [c_CNT_W-1:0] c_STROBE_LD = c_CNT_W'(STROBE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD    = c_CNT_W'(GAP_CYC - 1);

    rtc_state_e         r_state, w_next_state;
    rtc_port_e          r_grant, w_grant;
    rtc_req_t           r_req, w_sel_req, w_txn;
    logic               w_any_req;
    logic               w_load, w_last_cyc, w_last_next;
    logic [c_CNT_W-1:0] w_load_val;

    logic       r_a_ack, r_b_ack, r_busy, r_cs_n, r_wr_n, r_rd_n, r_ad, r_bus_oe;
    logic [7:0] r_bus_out, r_a_rdata, r_b_rdata;
    logic       w_a_ack, w_b_ack, w_cs_n, w_wr_n, w_rd_n, w_ad, w_bus_oe;
    logic [7:0] w_bus_out;

    // ------------------------------------------------------------------
    // Arbitration (only acted on in IDLE)
    // ------------------------------------------------------------------
    assign w_any_req = a_req | b_req;

`ifdef RTC_RR_ARB_EN
    // r_grant remembers the last winner; it resets to B so A takes the
    // first tie after reset.
    always_comb begin
        w_grant = PORT_A;
        if (a_req && b_req) begin
            w_grant = (r_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (!a_req) begin
            w_grant = PORT_B;
        end
    end
`else
    // Fixed priority: the config path always wins; B may starve.
    always_comb begin
        w_grant = a_req ? PORT_A : PORT_B;
    end
`endif

    assign w_sel_req = (w_grant == PORT_A) ? '{we: a_we, addr: a_addr, wdata: a_wdata}
                                           : '{we: b_we, addr: b_addr, wdata: b_wdata};

    // Transaction that the next cycle's outputs belong to: on the IDLE exit
    // the latch has not been written yet, so use the arbiter's selection.
    assign w_txn = (r_state == S_IDLE) ? w_sel_req : r_req;

    // ------------------------------------------------------------------
    // Phase timer
    // ------------------------------------------------------------------
    assign w_load     = (w_next_state != r_state);
    assign w_load_val = ((w_next_state == S_ADDR_ST) || (w_next_state == S_DATA_ST))
                        ? c_STROBE_LD : c_GAP_LD;

    rtc_phase_timer #(
        .CNT_W     (c_CNT_W)
    ) u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .load_val  (w_load_val),
        .last_cyc  (w_last_cyc),
        .last_next (w_last_next)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req)  w_next_state = S_ADDR_SU;
            S_ADDR_SU: if (w_last_cyc) w_next_state = S_ADDR_ST;
            S_ADDR_ST: if (w_last_cyc) w_next_state = S_ADDR_HD;
            S_ADDR_HD: if (w_last_cyc) w_next_state = S_DATA_SU;
            S_DATA_SU: if (w_last_cyc) w_next_state = S_DATA_ST;
            S_DATA_ST: if (w_last_cyc) w_next_state = S_DATA_HD;
            S_DATA_HD: if (w_last_cyc) w_next_state = S_RELEASE;
            S_RELEASE: if (w_last_cyc) w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from the next state and registered below so
    // every pin is a flop and tracks its state cycle-exactly.
    // ------------------------------------------------------------------
    always_comb begin
        w_cs_n    = c_CS_N_IDLE;
        w_wr_n    = c_WR_N_IDLE;
        w_rd_n    = c_RD_N_IDLE;
        w_ad      = c_AD_IDLE;
        w_bus_oe  = c_BUS_OE_IDLE;
        w_bus_out = c_BUS_OUT_IDLE;
        w_a_ack   = 1'b0;
        w_b_ack   = 1'b0;
        case (w_next_state)
            S_ADDR_SU, S_ADDR_ST, S_ADDR_HD: begin
                w_cs_n    = 1'b0;
                w_ad      = 1'b0;
                w_bus_oe  = 1'b1;
                w_bus_out = w_txn.addr;
                // Address is latched by the RTC on WR for reads and writes.
                if (w_next_state == S_ADDR_ST) w_wr_n = 1'b0;
            end
            S_DATA_SU, S_DATA_ST, S_DATA_HD: begin
                w_cs_n = 1'b0;
                if (w_txn.we) begin
                    w_bus_oe  = 1'b1;
                    w_bus_out = w_txn.wdata;
                    if (w_next_state == S_DATA_ST) w_wr_n = 1'b0;
                end else if (w_next_state == S_DATA_ST) begin
                    w_rd_n = 1'b0;
                end
            end
            S_RELEASE: begin
                // Ack on the last RELEASE cycle so req is low again by IDLE.
                if (w_last_next) begin
                    w_a_ack = (r_grant == PORT_A);
                    w_b_ack = (r_grant == PORT_B);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_n    <= c_CS_N_IDLE;
            r_wr_n    <= c_WR_N_IDLE;
            r_rd_n    <= c_RD_N_IDLE;
            r_ad      <= c_AD_IDLE;
            r_bus_oe  <= c_BUS_OE_IDLE;
            r_bus_out <= c_BUS_OUT_IDLE;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cs_n    <= w_cs_n;
            r_wr_n    <= w_wr_n;
            r_rd_n    <= w_rd_n;
            r_ad      <= w_ad;
            r_bus_oe  <= w_bus_oe;
            r_bus_out <= w_bus_out;
            r_a_ack   <= w_a_ack;
            r_b_ack   <= w_b_ack;
            r_busy    <= (w_next_state != S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Request latch and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req   <= '0;
            r_grant <= PORT_B;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            r_req   <= w_sel_req;
            r_grant <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_rdata <= 8'h00;
            r_b_rdata <= 8'h00;
        end else if ((r_state == S_DATA_ST) && w_last_cyc && !r_req.we) begin
            if (r_grant == PORT_A) r_a_rdata <= bus_in;
            else                   r_b_rdata <= bus_in;
        end
    end

    assign a_ack   = r_a_ack;
    assign b_ack   = r_b_ack;
    assign a_rdata = r_a_rdata;
    assign b_rdata = r_b_rdata;
    assign busy    = r_busy;
    assign cs_n    = r_cs_n;
    assign wr_n    = r_wr_n;
    assign rd_n    = r_rd_n;
    assign ad      = r_ad;
    assign bus_out = r_bus_out;
    assign bus_oe  = r_bus_oe;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
// ============================================================================
// Module      : tb_rtc_bus_sequencer
// Description : Self-checking bench for rtc_bus_sequencer. A cycle-level
//               reference derives every strobe from the transaction's offset
//               since its request was sampled. A second instance with
//               one-cycle strobes checks back-to-back throughput.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rtc_bus_sequencer;

    localparam int G = 1;
    localparam int S = 2;
    localparam int L = 5*G + 2*S;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req, we;
    logic [7:0] addr [2];
    logic [7:0] wdata [2];
    logic       a_ack, b_ack, busy, cs_n, wr_n, rd_n, ad, bus_oe;
    logic [7:0] a_rdata, b_rdata, bus_out, bus_in, bus_val;

    // RTC model: drives the bus only while RD is asserted.
    assign bus_in = (rd_n == 1'b0) ? bus_val : 8'h00;

    rtc_bus_sequencer #(.STROBE_CYC(S), .GAP_CYC(G)) dut (
        .clk(clk), .reset(rst),
        .a_req(req[0]), .b_req(req[1]), .a_we(we[0]), .b_we(we[1]),
        .a_addr(addr[0]), .b_addr(addr[1]), .a_wdata(wdata[0]), .b_wdata(wdata[1]),
        .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .busy(busy), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .ad(ad),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    // Throughput instance: STROBE=GAP=1, only B requesting.
    logic       b2_req, b2_ack, b2_busy;
    logic       d2_a_ack, d2_cs_n, d2_wr_n, d2_rd_n, d2_ad, d2_oe;
    logic [7:0] d2_a_rdata, d2_b_rdata, d2_bus_out;

    rtc_bus_sequencer #(.STROBE_CYC(1), .GAP_CYC(1)) dut2 (
        .clk(clk), .reset(rst),
        .a_req(1'b0), .b_req(b2_req), .a_we(1'b0), .b_we(1'b0),
        .a_addr(8'h00), .b_addr(8'h30), .a_wdata(8'h00), .b_wdata(8'h00),
        .a_ack(d2_a_ack), .b_ack(b2_ack), .a_rdata(d2_a_rdata), .b_rdata(d2_b_rdata),
        .busy(b2_busy), .cs_n(d2_cs_n), .wr_n(d2_wr_n), .rd_n(d2_rd_n), .ad(d2_ad),
        .bus_out(d2_bus_out), .bus_oe(d2_oe), .bus_in(8'h5A)
    );

    // Reference state
    int         total = 0, bad = 0, cyc = 0;
    bit         m_active = 0, m_we = 0, m_after_rst = 0;
    int         m_t0 = 0, m_port = 0, m_last = 1;
    logic [7:0] m_addr = 0, m_wdata = 0;
    logic [7:0] m_rdata [2];
    bit         hold [2];
    bit         bus_fixed = 0;
    int         obs_order [$];
    bit         b2_mon = 0;
    int         b2_prev = -1, b2_idle = 0, b2_acks = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit in_txn(input int n);
        return m_active && (n > m_t0) && (n <= m_t0 + L);
    endfunction

    // Mirrors what the DUT will see at the coming edge.
    task automatic sample_model();
        int p;
        if (rst) begin
            m_active    = 0;
            m_rdata[0]  = 8'h00;
            m_rdata[1]  = 8'h00;
            m_last      = 1;
            m_after_rst = 1;
        end else if (!in_txn(cyc) && (req != 2'b00)) begin
            if (req == 2'b11) begin
`ifdef RTC_RR_ARB_EN
                p = (m_last == 0) ? 1 : 0;
`else
                p = 0;
`endif
            end else begin
                p = req[0] ? 0 : 1;
            end
            m_active = 1;
            m_t0     = cyc;
            m_port   = p;
            m_we     = we[p];
            m_addr   = addr[p];
            m_wdata  = wdata[p];
            m_last   = p;
            bus_val  = bus_fixed ? 8'h47 : 8'($urandom);
        end
    endtask

    task automatic tick();
        int k;
        bit it;
        logic e_oe;
        sample_model();
        @(negedge clk);
        cyc++;
        it = in_txn(cyc);
        k  = cyc - m_t0;
        chk1("busy", busy, it);
        chk1("cs_n", cs_n, !(it && k <= 4*G+2*S));
        chk1("ad",   ad,   !(it && k <= 2*G+S));
        chk1("wr_n", wr_n, !(it && ((k >= G+1 && k <= G+S) ||
                                    (m_we && k >= 3*G+S+1 && k <= 3*G+2*S))));
        chk1("rd_n", rd_n, !(it && !m_we && k >= 3*G+S+1 && k <= 3*G+2*S));
        e_oe = it && (k <= 2*G+S || (m_we && k <= 4*G+2*S));
        chk1("bus_oe", bus_oe, e_oe);
        if (e_oe)             chk("bus_out", bus_out, (k <= 2*G+S) ? m_addr : m_wdata);
        else if (m_after_rst) chk("bus_out_rst", bus_out, 8'h00);
        m_after_rst = 0;
        chk1("a_ack", a_ack, it && k == L && m_port == 0);
        chk1("b_ack", b_ack, it && k == L && m_port == 1);
        chk("a_rdata", a_rdata, m_rdata[0]);
        chk("b_rdata", b_rdata, m_rdata[1]);
        if (a_ack) obs_order.push_back(0);
        if (b_ack) obs_order.push_back(1);
        if (it && k == 3*G+2*S && !m_we) m_rdata[m_port] = bus_val;
        if (it && k == L) begin
            if (hold[m_port]) begin
                we[m_port]    = 1'($urandom);
                addr[m_port]  = 8'($urandom);
                wdata[m_port] = 8'($urandom);
            end else begin
                req[m_port] = 1'b0;
            end
        end
        if (b2_mon) begin
            if (!b2_busy) b2_idle++;
            if (b2_ack) begin
                if (b2_prev >= 0) begin
                    chk("b2_period", 8'(cyc - b2_prev), 8'd8);
                    chk("b2_idle_gap", 8'(b2_idle), 8'd1);
                end
                b2_prev = cyc;
                b2_idle = 0;
                b2_acks++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (req != 2'b00 || in_txn(cyc)); i++) tick();
        chk1("drain_timeout", (req != 2'b00) || in_txn(cyc), 1'b0);
        tick();
    endtask

    task automatic post(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    endtask

    initial begin
        int exp_order [4];
        bit found;
        rst = 1'b1; req = 2'b00; we = 2'b00; b2_req = 1'b0;
        addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
        hold[0] = 0; hold[1] = 0; bus_val = 8'h00;
        m_rdata[0] = 0; m_rdata[1] = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // A writes 0x15 to 0x21
        post(0, 1'b1, 8'h21, 8'h15);
        drain();

        // B reads 0x22, RTC returns 0x47
        bus_fixed = 1;
        post(1, 1'b0, 8'h22, 8'h00);
        drain();
        bus_fixed = 0;
        chk("b_rdata_47", b_rdata, 8'h47);
        chk("a_rdata_kept", a_rdata, 8'h00);

        // Simultaneous requests: A first, then B
        obs_order.delete();
        post(0, 1'b1, 8'($urandom), 8'($urandom));
        post(1, 1'b0, 8'($urandom), 8'h00);
        drain();
        chk("tie_count", 8'(obs_order.size()), 8'd2);
        if (obs_order.size() >= 2) begin
            chk("tie_first",  8'(obs_order[0]), 8'd0);
            chk("tie_second", 8'(obs_order[1]), 8'd1);
        end

        // Both ports re-request continuously
`ifdef RTC_RR_ARB_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        obs_order.delete();
        hold[0] = 1; hold[1] = 1;
        post(0, 1'($urandom), 8'($urandom), 8'($urandom));
        post(1, 1'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 200 && obs_order.size() < 4; i++) tick();
        hold[0] = 0; hold[1] = 0;
        chk1("order_timeout", obs_order.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < obs_order.size(); i++)
            chk($sformatf("order_%0d", i), 8'(obs_order[i]), 8'(exp_order[i]));
        drain();

        // Reset in the second DATA_ST cycle of an A read
        found = 0;
        post(0, 1'b0, 8'($urandom), 8'h00);
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            found = in_txn(cyc) && (cyc - m_t0 == 3*G+S+2);
        end
        chk1("rst_point_found", found, 1'b1);
        req[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        post(0, 1'b1, 8'($urandom), 8'($urandom));
        drain();

        // Random traffic on both ports; throughput instance runs alongside
        b2_req = 1'b1;
        b2_mon = 1;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++)
                if (!req[p] && $urandom_range(3) == 0)
                    post(p, 1'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        drain();
        chk1("b2_acks_seen", b2_acks > 10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
